pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the MIPS pipeline fetch stage.
- Holds the PC register and computes PC+INCR.
- Selects the next PC from exception, branch, return, jump, stall or increment.
- Keeps a small circular return-address stack (RAS) that predicts targets for jr $ra returns.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised next-PC selection and a small
// circular return-address stack used to predict jr $ra targets.
module pc_sequencer #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     INCR       = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned     DEPTH      = 4,
    parameter int unsigned     ALIGN_BITS = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] RetTarget,
    input  logic             Exception,
    input  logic [WIDTH-1:0] ExcVector,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             Redirect,
    output logic             AlignErr,
    output logic             RasEmpty,
    output logic             RasFull
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);

    // Architectural state
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redirect_q, redirect_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] ras_mem [DEPTH];

    // Next-PC selection
    logic [WIDTH-1:0] pc_add;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] ras_top;
    logic [PTR_W-1:0] top_ptr;
    logic             redirect_sel;
    logic             ras_empty;
    logic             ras_full;

    // RAS control
    logic             ras_act;
    logic             do_push;
    logic             do_pop;
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;

    assign pc_add    = pc_q + WIDTH'(INCR);
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CNT_MAX);
    assign top_ptr   = wr_ptr_q - PTR_W'(1);
    assign ras_top   = ras_mem[top_ptr];

    always_comb begin
        raw_target   = '0;
        redirect_sel = 1'b1;
        if (Exception) begin
            raw_target = ExcVector;
        end else if (BranchTaken) begin
            raw_target = BranchTarget;
        end else if (Ret) begin
            raw_target = ras_empty ? RetTarget : ras_top;
        end else if (Jump) begin
            raw_target = JumpTarget;
        end else begin
            redirect_sel = 1'b0;
        end
    end

    always_comb begin
        if (redirect_sel) begin
            pc_d = raw_target & ~ALIGN_MASK;
        end else if (Stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_add;
        end
        redirect_d = redirect_sel;
    end

    // A stalled fetch must not disturb the stack unless it is being redirected anyway.
    assign ras_act = !Stall || redirect_sel;
    assign do_push = Call && ras_act && !Exception;
    assign do_pop  = Ret && ras_act && !Exception && !BranchTaken;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ras_we    = 1'b0;
        ras_waddr = wr_ptr_q;
        if (Exception) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (do_push && do_pop && !ras_empty) begin
            // Return and call in one cycle: swap the top entry in place.
            ras_we    = 1'b1;
            ras_waddr = top_ptr;
        end else if (do_push) begin
            ras_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = ras_full ? count_q : count_q + CNT_W'(1);
        end else if (do_pop && !ras_empty) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Stack contents need no reset; only count and pointer define validity.
    always_ff @(posedge Clk) begin
        if (!Reset && ras_we) begin
            ras_mem[ras_waddr] <= pc_add;
        end
    end

    assign PCResult    = pc_q;
    assign PCAddResult = pc_add;
    assign Redirect    = redirect_q;
    assign AlignErr    = redirect_sel && ((raw_target & ALIGN_MASK) != '0);
    assign RasEmpty    = ras_empty;
    assign RasFull     = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model pushes expected
// post-edge state into a queue, which is popped and compared after each edge.
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchTaken, Jump, Call, Ret, Exception;
    logic [31:0] BranchTarget, JumpTarget, RetTarget, ExcVector;
    logic [31:0] PCResult, PCAddResult;
    logic        Redirect, AlignErr, RasEmpty, RasFull;

    pc_sequencer #(
        .WIDTH(32), .INCR(4), .RESET_PC(32'h0), .DEPTH(DEPTH), .ALIGN_BITS(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .Call(Call), .Ret(Ret), .RetTarget(RetTarget),
        .Exception(Exception), .ExcVector(ExcVector),
        .PCResult(PCResult), .PCAddResult(PCAddResult), .Redirect(Redirect),
        .AlignErr(AlignErr), .RasEmpty(RasEmpty), .RasFull(RasFull)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        redir;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_stack[$];  // back of queue is the top of the return stack
    logic [31:0] m_pc;
    bit          m_valid = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Reset = 0; Stall = 0; BranchTaken = 0; Jump = 0; Call = 0; Ret = 0; Exception = 0;
        BranchTarget = 0; JumpTarget = 0; RetTarget = 0; ExcVector = 0;
    endtask

    // Model one clock with the inputs currently driven, then compare after the edge.
    task automatic cycle();
        logic [31:0] raw, nxt;
        bit          sel, act, push, pop;
        exp_t        e, got;
        #1;
        sel = 1;
        raw = 0;
        if (Exception)        raw = ExcVector;
        else if (BranchTaken) raw = BranchTarget;
        else if (Ret)         raw = (m_stack.size() > 0) ? m_stack[$] : RetTarget;
        else if (Jump)        raw = JumpTarget;
        else                  sel = 0;
        if (m_valid) begin
            check_eq("pcadd", PCAddResult, m_pc + 32'd4);
            check_eq("alignerr", {31'b0, AlignErr}, {31'b0, sel && (raw[1:0] != 2'b00)});
        end
        if (Reset) begin
            m_pc = 32'h0;
            m_stack.delete();
            m_valid = 1;
            sel = 0;
        end else begin
            act  = !Stall || sel;
            push = Call && act && !Exception;
            pop  = Ret && act && !Exception && !BranchTaken;
            if (Exception) begin
                m_stack.delete();
            end else if (push && pop && m_stack.size() > 0) begin
                m_stack[m_stack.size()-1] = m_pc + 32'd4;
            end else begin
                if (pop && m_stack.size() > 0) void'(m_stack.pop_back());
                if (push) begin
                    m_stack.push_back(m_pc + 32'd4);
                    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
                end
            end
            if (sel)        nxt = {raw[31:2], 2'b00};
            else if (Stall) nxt = m_pc;
            else            nxt = m_pc + 32'd4;
            m_pc = nxt;
        end
        e.pc    = m_pc;
        e.redir = sel;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == DEPTH);
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            got = '{pc: PCResult, redir: Redirect, empty: RasEmpty, full: RasFull};
            check_eq("pc", got.pc, e.pc);
            check_eq("redirect", {31'b0, got.redir}, {31'b0, e.redir});
            check_eq("rasempty", {31'b0, got.empty}, {31'b0, e.empty});
            check_eq("rasfull", {31'b0, got.full}, {31'b0, e.full});
        end
        idle_inputs();
    endtask

    task automatic do_jump(input logic [31:0] t);
        Jump = 1; JumpTarget = t; cycle();
    endtask

    task automatic do_ret(input logic [31:0] fallback);
        Ret = 1; RetTarget = fallback; cycle();
    endtask

    initial begin
        idle_inputs();
        Reset = 1;
        cycle();
        Reset = 1;
        cycle();
        check_eq("reset_pc", PCResult, 32'h0);
        check_eq("reset_empty", {31'b0, RasEmpty}, 32'd1);
        for (int i = 0; i < 4; i++) cycle();
        check_eq("seq_pc", PCResult, 32'h10);

        // Stall holds, then increments
        for (int i = 0; i < 3; i++) begin
            Stall = 1; cycle();
        end
        check_eq("stall_hold", PCResult, 32'h10);
        cycle();
        check_eq("after_stall", PCResult, 32'h14);

        // Wrap at 2^32
        Exception = 1; ExcVector = 32'hFFFF_FFFC; cycle();
        check_eq("wrap_add", PCAddResult, 32'h0);
        cycle();
        check_eq("wrap_pc", PCResult, 32'h0);

        // Priority
        Jump = 1; JumpTarget = 32'h100; Call = 1; cycle();
        Exception = 1; ExcVector = 32'h8000_0180;
        BranchTaken = 1; BranchTarget = 32'h200; Jump = 1; JumpTarget = 32'h300; Call = 1;
        cycle();
        check_eq("exc_pc", PCResult, 32'h8000_0180);
        check_eq("exc_redir", {31'b0, Redirect}, 32'd1);
        check_eq("exc_ras_clear", {31'b0, RasEmpty}, 32'd1);
        BranchTaken = 1; BranchTarget = 32'h200; Jump = 1; JumpTarget = 32'h300; cycle();
        check_eq("br_pc", PCResult, 32'h200);
        cycle();
        check_eq("redir_1cyc", {31'b0, Redirect}, 32'd0);

        // Return-stack sequence
        do_jump(32'h100);
        Call = 1; cycle();
        do_jump(32'h400);
        Call = 1; cycle();
        do_ret(32'h0);
        check_eq("ret1", PCResult, 32'h404);
        do_ret(32'h0);
        check_eq("ret2", PCResult, 32'h104);
        do_ret(32'h900);
        check_eq("ret3", PCResult, 32'h900);
        check_eq("ret3_empty", {31'b0, RasEmpty}, 32'd1);

        // Overflow: five calls, oldest dropped
        for (int k = 0; k < 5; k++) begin
            Jump = 1; JumpTarget = 32'h2000 + 32'(k) * 32'h100; Call = 1; cycle();
        end
        check_eq("ovf_full", {31'b0, RasFull}, 32'd1);
        for (int k = 0; k < 5; k++) do_ret(32'hA00);
        check_eq("ovf_fallback", PCResult, 32'hA00);

        // Alignment
        Jump = 1; JumpTarget = 32'h1006; #1;
        check_eq("align_err", {31'b0, AlignErr}, 32'd1);
        cycle();
        check_eq("align_pc", PCResult, 32'h1004);

        // Call + Ret collision
        do_jump(32'h4FC);
        Call = 1; cycle();
        do_jump(32'h600);
        Call = 1; Ret = 1; cycle();
        check_eq("coll_pc", PCResult, 32'h500);
        do_ret(32'h0);
        check_eq("coll_top", PCResult, 32'h604);

        // Stalled call is ignored; ret while stalled still redirects
        Stall = 1; Call = 1; cycle();
        Stall = 1; Ret = 1; RetTarget = 32'hB00; cycle();

        // Reset mid-operation
        Reset = 1; Stall = 1; Exception = 1; ExcVector = 32'h40; Call = 1; cycle();
        check_eq("midreset_pc", PCResult, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            Reset        = ($urandom_range(0, 99) == 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Exception    = ($urandom_range(0, 19) == 0);
            BranchTaken  = ($urandom_range(0, 7) == 0);
            Jump         = ($urandom_range(0, 5) == 0);
            Call         = ($urandom_range(0, 3) == 0);
            Ret          = ($urandom_range(0, 3) == 0);
            ExcVector    = $urandom;
            BranchTarget = $urandom;
            JumpTarget   = $urandom;
            RetTarget    = $urandom;
            cycle();
        end

        if (sb.size() != 0) check_eq("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
